mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for a 4:1 data mux shared by four requesters. Owns the 2-bit mux select: grants one requester at a time, holds the grant while that requester keeps its request high, and steers the winner's data to a single registered-select output. Sits in front of the existing 4:1 mux datapath and replaces free-running select stimulus with a fair, handshaked controller.

## Interface
- `DW`, default 8, width of each data input and of `dout`.
- `MAX_BURST`, default 4, maximum consecutive grant cycles per owner while others wait. Used only with `MUX4_ARB_BURST_LIMIT_EN`. Legal range 1..255.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request per requester; `req[i]` is requester i.
- `din0`..`din3`  in  DW each  requester data; only the granted requester's data is forwarded.
- `gnt`  out  4  registered one-hot grant; all zero when idle.
- `sel`  out  2  registered mux select equal to the index of the current or most recent owner.
- `vld`  out  1  registered; high exactly when `gnt` is non-zero.
- `dout`  out  DW  combinational `din[sel]` when `vld`=1; all zeros when `vld`=0.

## Operation
- Two states: IDLE (no owner) and GRANT (one owner).
- Round-robin pointer `ptr` (2 bits) marks the highest-priority requester. Priority order is `ptr`, `ptr`+1, `ptr`+2, `ptr`+3, all mod 4.
- IDLE: if `req`=0, stay. Otherwise pick the first requester in priority order, then set `gnt`, `sel`, and `vld`, go to GRANT, and set `ptr` = winner+1 mod 4.
- GRANT with `req[owner]`=1: hold the grant unchanged.
- GRANT with `req[owner]`=0 and other requests pending: re-arbitrate at the same edge with no bubble cycle. The winner is picked from `ptr`, which makes the old owner lowest priority.
- GRANT with `req[owner]`=0 and no other requests: clear `gnt` and `vld`, `sel` holds, go to IDLE.
- Requests from non-owners never preempt the owner, except through the burst limit.
- `sel` changes only when a new grant is issued. Once `vld` is high, `sel` and `gnt` always agree.
- Reset values: `gnt`=4'b0000, `sel`=2'b00, `vld`=0, `dout`=0, `ptr`=0, state IDLE, burst count 0.
- Reset asserted mid-grant clears all outputs immediately, without waiting for `clk`. After release, arbitration restarts from `ptr`=0.

## Timing
- Grant latency: a request sampled high at edge N while IDLE gives `gnt`/`vld` high after edge N. The minimum is 1 cycle.
- Release: owner drops `req` before edge N. After edge N, either the next owner is granted or `gnt`=0.
- Handover between owners takes zero idle cycles. `dout` switches with `sel` in the same cycle.
- Simultaneous requests at the same edge resolve strictly by `ptr` order.
- A requester may drop `req` only after seeing its `gnt`. Dropping before grant simply withdraws the request.
- `dout` has no register, so its delay is the combinational mux delay from `sel` and `dinX`.

## Configuration
- `MUX4_ARB_BURST_LIMIT_EN` defined:
  - A burst counter is set to 1 on each new grant and incremented each cycle the grant is held. It saturates at `MAX_BURST`.
  - At an edge where the count equals `MAX_BURST` and any other requester is pending, the grant is forced to the next requester in `ptr` order. The old owner keeps its request and re-competes at lowest priority.
  - If no other requester is pending, the owner keeps the grant and the counter stays at `MAX_BURST`.
- `MUX4_ARB_BURST_LIMIT_EN` undefined: there is no counter and no `MAX_BURST` logic. An owner holds the grant for as long as its `req` stays high.

## Test plan
- Reset and idle: `rst_n`=0 then 1, with `req`=0 for 5 cycles. Required: `gnt`=0000, `sel`=00, `vld`=0, `dout`=0 throughout.
- Single request: `req`=0100, `din2`=8'hA5, held for 3 cycles then dropped. Required: `gnt`=0100, `sel`=10, `dout`=A5 starting 1 cycle after the request; `gnt`=0000 one cycle after `req` drops.
- Fair rotation: `req`=1111 held, each owner dropping its own request for one cycle after 2 granted cycles. Required: grant order 0,1,2,3,0 with no idle cycle between owners.
- Preemption check (macro off): `req`=0001 held for 10 cycles, `req[3]` rising at cycle 2. Required: `gnt`=0001 for all 10 cycles, then `gnt`=1000 at the next edge after `req[0]` drops.
- Burst limit (macro on, `MAX_BURST`=4): `req`=0011 held. Required: `gnt` alternates 0001 for 4 cycles and 0010 for 4 cycles, repeating.
- Async reset mid-grant: `gnt`=0010, then `rst_n` pulled low between edges. Required: `gnt`=0, `vld`=0, and `dout`=0 before the next `clk` edge; after release with `req`=1111, the first grant is 0001.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 4:1 data mux.
// Define MUX4_ARB_BURST_LIMIT_EN to cap each owner's tenure at MAX_BURST cycles while others wait.
module mux4_rr_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic          vld,
    output logic [DW-1:0] dout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [1:0]  sel_nxt;
    logic [3:0]  gnt_nxt;
    logic        vld_nxt;
    logic [3:0]  cand;
    logic        found;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        arb;

`ifdef MUX4_ARB_BURST_LIMIT_EN
    logic [7:0]  burst_cnt;
    logic        burst_hit;

    assign burst_hit = (burst_cnt == 8'(MAX_BURST));
`endif

    // Masking out the current owner lets one picker serve idle arbitration,
    // release handover and forced burst handover alike.
    always_comb begin
        cand  = req & ~gnt;
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        vld_nxt   = vld;
        ptr_nxt   = ptr;
        arb       = 1'b0;
        case (state)
            IDLE: begin
                if (found) arb = 1'b1;
            end
            GRANT: begin
                if (~|(req & gnt)) begin
                    if (found) begin
                        arb = 1'b1;
                    end else begin
                        gnt_nxt   = 4'b0000;
                        vld_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                end
`ifdef MUX4_ARB_BURST_LIMIT_EN
                else if (burst_hit && found) begin
                    arb = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        if (arb) begin
            gnt_nxt   = 4'b0001 << win;
            sel_nxt   = win;
            vld_nxt   = 1'b1;
            ptr_nxt   = win + 2'd1;
            state_nxt = GRANT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'b00;
            vld   <= 1'b0;
            ptr   <= 2'b00;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            vld   <= vld_nxt;
            ptr   <= ptr_nxt;
        end
    end

`ifdef MUX4_ARB_BURST_LIMIT_EN
    // Counts cycles of the current tenure; saturates so a lone owner keeps its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= 8'd0;
        end else if (arb) begin
            burst_cnt <= 8'd1;
        end else if (state_nxt == IDLE) begin
            burst_cnt <= 8'd0;
        end else if (!burst_hit) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        dout = '0;
        if (vld) begin
            case (sel)
                2'd0:    dout = din0;
                2'd1:    dout = din1;
                2'd2:    dout = din2;
                default: dout = din3;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter; burst-limit checks follow MUX4_ARB_BURST_LIMIT_EN.
module tb_mux4_rr_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req;
    logic [DW-1:0] din0, din1, din2, din3;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          vld;
    logic [DW-1:0] dout;

    int testsRun  = 0;
    int failCount = 0;

    logic [7:0] dinTab [4] = '{8'h11, 8'h22, 8'hA5, 8'h33};

    mux4_rr_arbiter #(.DW(DW), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din0  (din0),
        .din1  (din1),
        .din2  (din2),
        .din3  (din3),
        .gnt   (gnt),
        .sel   (sel),
        .vld   (vld),
        .dout  (dout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] eg, input logic [1:0] es,
                            input logic ev, input logic [7:0] ed);
        checkOutput({tag, ".gnt"},  32'(gnt),  32'(eg));
        checkOutput({tag, ".sel"},  32'(sel),  32'(es));
        checkOutput({tag, ".vld"},  32'(vld),  32'(ev));
        checkOutput({tag, ".dout"}, 32'(dout), 32'(ed));
    endtask

    // Drive req, then sample just after the next rising edge.
    task automatic applyStimulus(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        din0  = dinTab[0];
        din1  = dinTab[1];
        din2  = dinTab[2];
        din3  = dinTab[3];

        #12;
        checkAll("in_reset", 4'b0000, 2'd0, 1'b0, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0000);
            checkAll("idle", 4'b0000, 2'd0, 1'b0, 8'h00);
        end

        // Single requester 2 for three cycles, then release.
        req = 4'b0100;
        #1;
        checkOutput("single.latency", 32'(gnt), 32'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0100);
            checkAll("single", 4'b0100, 2'd2, 1'b1, 8'hA5);
        end
        applyStimulus(4'b0000);
        checkAll("single.release", 4'b0000, 2'd2, 1'b0, 8'h00);

        // Fair rotation from a fresh pointer: 0,1,2,3,0 with no idle gap.
        pulseReset();
        applyStimulus(4'b1111);
        for (int k = 0; k < 5; k++) begin
            int o;
            o = k % 4;
            checkAll("rot.first", 4'(1 << o), 2'(o), 1'b1, dinTab[o]);
            applyStimulus(4'b1111);
            checkAll("rot.second", 4'(1 << o), 2'(o), 1'b1, dinTab[o]);
            applyStimulus(4'b1111 & ~4'(1 << o));
            req = 4'b1111;
        end
        checkAll("rot.after", 4'b0010, 2'd1, 1'b1, 8'h22);
        applyStimulus(4'b0000);
        checkAll("rot.idle", 4'b0000, 2'd1, 1'b0, 8'h00);

`ifndef MUX4_ARB_BURST_LIMIT_EN
        // Owner 0 is never preempted by a later request from 3.
        pulseReset();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(c >= 2 ? 4'b1001 : 4'b0001);
            checkOutput("hold.gnt", 32'(gnt), 32'h1);
        end
        applyStimulus(4'b1000);
        checkAll("hold.handover", 4'b1000, 2'd3, 1'b1, 8'h33);
        applyStimulus(4'b0000);
        checkAll("hold.idle", 4'b0000, 2'd3, 1'b0, 8'h00);
`else
        // Two persistent requesters alternate in 4-cycle bursts.
        pulseReset();
        for (int c = 0; c < 16; c++) begin
            int o;
            applyStimulus(4'b0011);
            o = (c / 4) % 2;
            checkAll("burst", 4'(1 << o), 2'(o), 1'b1, dinTab[o]);
        end
        // A lone owner keeps its grant past the limit.
        applyStimulus(4'b0000);
        for (int c = 0; c < 7; c++) begin
            applyStimulus(4'b0100);
            checkOutput("burst.lone", 32'(gnt), 32'h4);
        end
        applyStimulus(4'b0000);
`endif

        // Asynchronous reset in the middle of a grant.
        applyStimulus(4'b0010);
        checkAll("areset.pre", 4'b0010, 2'd1, 1'b1, 8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("areset.async", 4'b0000, 2'd0, 1'b0, 8'h00);
        req = 4'b1111;
        #2;
        rst_n = 1'b1;
        applyStimulus(4'b1111);
        checkAll("areset.restart", 4'b0001, 2'd0, 1'b1, 8'h11);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
